alarm_clk_digit_sched: RTL

Sequencer that owns the write side of the six 4-bit digit output ports (H1 H0 M1 M0 S1 S0) of the alarm clock display. It accepts a packed BCD time snapshot from the timekeeping logic and issues single-cycle Avalon-MM writes only to digits whose value changed. It sits between the time/alarm core and the digit PIO slaves, replacing per-digit software writes.

---
 rtl/alarm_clk_pkg.sv | 51 +++++
 rtl/alarm_clk_dirty_pick.sv | 27 ++
 rtl/alarm_clk_digit_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alarm_clk_pkg.sv
// Shared constants, state type and BCD helpers for the alarm clock digit write sequencer.
// The snapshot legality check is only used when ALARM_CLK_BCD_CHECK_EN is defined.
package alarm_clk_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIG_W      = 4;
  localparam int SNAP_W     = NUM_DIGITS * DIG_W;
  localparam int IDX_W      = 3;

  localparam int DIG_S0 = 0;
  localparam int DIG_S1 = 1;
  localparam int DIG_M0 = 2;
  localparam int DIG_M1 = 3;
  localparam int DIG_H0 = 4;
  localparam int DIG_H1 = 5;

  localparam logic [DIG_W-1:0] BCD_MAX      = 4'd9;
  localparam logic [DIG_W-1:0] H1_MAX       = 4'd2;
  localparam logic [DIG_W-1:0] H0_MAX_AT_20 = 4'd3;
  localparam logic [DIG_W-1:0] TENS_MAX     = 4'd5;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } sched_state_e;

  function automatic logic [DIG_W-1:0] digit_of(input logic [SNAP_W-1:0] snap,
                                                input logic [IDX_W-1:0]  idx);
    logic [DIG_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == IDX_W'(i)) d = snap[i*DIG_W +: DIG_W];
    return d;
  endfunction

  function automatic logic snap_is_valid(input logic [SNAP_W-1:0] snap);
    logic ok;
    logic [DIG_W-1:0] h1, h0;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (snap[i*DIG_W +: DIG_W] > BCD_MAX) ok = 1'b0;
    h1 = snap[DIG_H1*DIG_W +: DIG_W];
    h0 = snap[DIG_H0*DIG_W +: DIG_W];
    if (h1 > H1_MAX) ok = 1'b0;
    if (h1 == H1_MAX && h0 > H0_MAX_AT_20) ok = 1'b0;
    if (snap[DIG_M1*DIG_W +: DIG_W] > TENS_MAX) ok = 1'b0;
    if (snap[DIG_S1*DIG_W +: DIG_W] > TENS_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/alarm_clk_dirty_pick.sv
// Combinational picker: one-hot and index of the highest set bit of the dirty mask.
module alarm_clk_dirty_pick
  import alarm_clk_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] dirty,
  output logic [NUM_DIGITS-1:0] sel_oh,
  output logic [IDX_W-1:0]      sel_idx,
  output logic                  any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    any     = 1'b0;
    // Ascending scan: the last hit, i.e. the highest index, wins.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dirty[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_idx   = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_clk_digit_sched.sv
// Writes only changed BCD digits to the six digit PIO slaves, one Avalon-MM write per cycle.
// Define ALARM_CLK_BCD_CHECK_EN to reject illegal time snapshots and raise sticky bcd_err.
module alarm_clk_digit_sched
  import alarm_clk_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SNAP_W-1:0]     time_bcd,
  input  logic                  update_valid,
  input  logic                  force_refresh,
  output logic [NUM_DIGITS-1:0] chipselect,
  output logic                  write_n,
  output logic [1:0]            address,
  output logic [31:0]           writedata,
  output logic                  busy,
  output logic                  pending,
  output logic                  bcd_err
);

  sched_state_e          state_q, state_d;
  logic [SNAP_W-1:0]     shadow_q, shadow_d;
  logic                  shadow_valid_q, shadow_valid_d;
  logic                  refresh_q, refresh_d;
  logic                  pending_q, pending_d;
  logic [SNAP_W-1:0]     pend_snap_q, pend_snap_d;
  logic [SNAP_W-1:0]     snap_q, snap_d;
  logic [NUM_DIGITS-1:0] dirty_q, dirty_d;
  logic [NUM_DIGITS-1:0] cs_q;
  logic                  write_n_q;
  logic [DIG_W-1:0]      wd_q, wd_d;
  logic                  bcd_err_q, bcd_err_d;

  logic                  snap_ok, accept, seq_active, start_req, refresh_eff;
  logic [SNAP_W-1:0]     start_snap, src_snap;
  logic [NUM_DIGITS-1:0] start_dirty, pick_src, pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;

  alarm_clk_dirty_pick u_pick (
    .dirty   (pick_src),
    .sel_oh  (pick_oh),
    .sel_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
`ifdef ALARM_CLK_BCD_CHECK_EN
    snap_ok   = snap_is_valid(time_bcd);
    bcd_err_d = bcd_err_q | (update_valid & ~snap_ok);
`else
    snap_ok   = 1'b1;
    bcd_err_d = 1'b0;
`endif
    accept      = update_valid & snap_ok;
    // More writes remain after the one on the bus; otherwise this cycle may start a sequence.
    seq_active  = (state_q == ST_WRITE) && (dirty_q != '0);
    start_req   = !seq_active && (accept || pending_q);
    start_snap  = accept ? time_bcd : pend_snap_q;
    refresh_eff = refresh_q | force_refresh;

    for (int i = 0; i < NUM_DIGITS; i++)
      start_dirty[i] = (start_snap[i*DIG_W +: DIG_W] != shadow_q[i*DIG_W +: DIG_W])
                       | ~shadow_valid_q | refresh_eff;

    pick_src = seq_active ? dirty_q : (start_req ? start_dirty : '0);
    src_snap = seq_active ? snap_q : start_snap;

    state_d        = pick_any ? ST_WRITE : ST_IDLE;
    dirty_d        = pick_src & ~pick_oh;
    snap_d         = start_req ? start_snap : snap_q;
    wd_d           = pick_any ? digit_of(src_snap, pick_idx) : '0;
    shadow_valid_d = shadow_valid_q | (pick_any && dirty_d == '0);
    refresh_d      = start_req ? 1'b0 : refresh_eff;

    shadow_d = shadow_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (pick_oh[i]) shadow_d[i*DIG_W +: DIG_W] = wd_d;

    pending_d   = pending_q;
    pend_snap_d = pend_snap_q;
    if (seq_active && accept) begin
      pending_d   = 1'b1;
      pend_snap_d = time_bcd;
    end else if (start_req) begin
      pending_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      refresh_q      <= 1'b0;
      pending_q      <= 1'b0;
      dirty_q        <= '0;
      cs_q           <= '0;
      write_n_q      <= 1'b1;
      wd_q           <= '0;
      bcd_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      refresh_q      <= refresh_d;
      pending_q      <= pending_d;
      dirty_q        <= dirty_d;
      cs_q           <= pick_oh;
      write_n_q      <= ~pick_any;
      wd_q           <= wd_d;
      bcd_err_q      <= bcd_err_d;
    end
  end

  // NOTE: snapshot data registers are left unreset; they are only read once a valid flag qualifies them.
  always_ff @(posedge clk) begin
    snap_q      <= snap_d;
    pend_snap_q <= pend_snap_d;
  end

  assign chipselect = cs_q;
  assign write_n    = write_n_q;
  assign address    = 2'b00;
  assign writedata  = {28'b0, wd_q};
  assign busy       = (state_q == ST_WRITE);
  assign pending    = pending_q;
  assign bcd_err    = bcd_err_q;

endmodule
